alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data path width in bits (legal values 4..64).
REQ-002 The module SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the shift counter width.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present on op/a/b.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  3  operation: 000 ADD, 001 SUB, 010 SHR, 011 SHL, 100 AND, 101 OR, 110 XOR, 111 PASS.
REQ-008 a  input  WIDTH  first operand / shift source.
REQ-009 b  input  WIDTH  second operand / unsigned shift amount.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero, carry, negative  output  1 each  registered flags for result.

Function
REQ-014 Accept SHALL occur on a rising edge where in_valid && in_ready; op/a/b are captured then and not sampled again.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE; in_ready = (state==IDLE) || (state==DONE && out_ready); out_valid = (state==DONE).
REQ-016 ADD, SUB, AND, OR, XOR, PASS SHALL complete in one cycle: accept edge k -> DONE with result at edge k (out_valid high in cycle k+1).
REQ-017 ADD: result = (a+b) mod 2^WIDTH, carry = carry-out of bit WIDTH-1.
REQ-018 SUB: result = (a-b) mod 2^WIDTH, carry = 1 iff a < b unsigned (borrow).
REQ-019 AND/OR/XOR: bitwise a op b; PASS: result = a; carry = 0 for all four.
REQ-020 SHR/SHL (logical, zero fill): if b == 0 -> DONE at accept edge with result = a, carry = 0.
REQ-021 If b >= WIDTH -> DONE at accept edge with result = 0, carry = 0.
REQ-022 Otherwise enter SHIFT with counter = b; each SHIFT cycle shifts one bit, carry = bit shifted out, counter decrements; on the edge where counter reaches 0 enter DONE; out_valid first high b cycles after accept edge +1 (latency b+1 cycles).
REQ-023 zero = (result == 0); negative = result[WIDTH-1]; both valid whenever out_valid.
REQ-024 In SHIFT, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-025 In DONE with out_ready=0, result and flags SHALL hold stable and in_ready SHALL be 0.
REQ-026 In DONE with out_ready=1 and in_valid=1, handoff and new accept SHALL occur on the same edge (back-to-back, no bubble); with in_valid=0 go to IDLE.
REQ-027 result and flags SHALL only change on accept or during SHIFT.

Reset
REQ-028 reset assertion SHALL immediately force state IDLE, counter 0, result 0, zero 0, carry 0, negative 0, out_valid 0, regardless of state (abandons in-progress shift).
REQ-029 in_ready SHALL be 1 during and after reset; first accept possible on the first rising edge with reset low.

Verification (WIDTH=8)
REQ-030 ADD a=0xF0 b=0x20 -> result 0x10, carry 1, zero 0, negative 0, out_valid one cycle after accept.
REQ-031 SUB 0x05-0x05 -> 0x00 zero 1 carry 0; then SUB 0x03-0x05 -> 0xFE carry 1 negative 1, issued back-to-back with no idle cycle.
REQ-032 SHL a=0x81 b=3 -> in_ready 0 for 3 cycles, out_valid 4 cycles after accept, result 0x08, carry 0; SHR a=0x81 b=1 -> result 0x40, carry 1, latency 2.
REQ-033 SHL a=0xFF b=9 -> result 0x00, carry 0, zero 1, latency 1; SHR b=0 -> result = a, latency 1.
REQ-034 XOR 0xAA^0x0F with out_ready low 3 cycles -> result 0xA5 stable, in_ready 0, then released with in_valid high -> next op accepted on release edge.
REQ-035 reset pulsed mid SHR a=0x80 b=7 -> out_valid and result 0 immediately, in_ready 1; following ADD 0x01+0x01 -> 0x02 correct.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle logic/arith ops and bit-serial shifts
// Results are held in DONE until the consumer takes them; a new request can be accepted on the same edge.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             shl_q, shl_d;
  logic             load;
  logic             accept;
  logic [WIDTH:0]   sum;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      shl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      shl_q   <= shl_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    carry_d  = carry_q;
    shl_d    = shl_q;
    load     = 1'b0;
    sum      = '0;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    if (accept) begin
      load    = 1'b1;
      state_d = DONE;
      carry_d = 1'b0;
      unique case (op)
        OP_ADD: begin
          sum     = {1'b0, a} + {1'b0, b};
          res_d   = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
        end
        OP_SUB: begin
          res_d   = a - b;
          carry_d = (a < b);
        end
        OP_SHR, OP_SHL: begin
          shl_d = (op == OP_SHL);
          if (b == '0) begin
            res_d = a;
          end else if (b >= WIDTH_V) begin
            res_d = '0;
          end else begin
            // Operand parks in the result register and is shifted in place.
            res_d   = a;
            cnt_d   = b[CNT_W-1:0];
            state_d = SHIFT;
          end
        end
        OP_AND:  res_d = a & b;
        OP_OR:   res_d = a | b;
        OP_XOR:  res_d = a ^ b;
        OP_PASS: res_d = a;
      endcase
    end else begin
      unique case (state_q)
        SHIFT: begin
          load = 1'b1;
          if (shl_q) begin
            res_d   = {res_q[WIDTH-2:0], 1'b0};
            carry_d = res_q[WIDTH-1];
          end else begin
            res_d   = {1'b0, res_q[WIDTH-1:1]};
            carry_d = res_q[0];
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: ;
      endcase
    end

    // Flags follow the result only when it is loaded or shifted, otherwise they hold.
    zero_d = load ? (res_d == '0) : zero_q;
    neg_d  = load ? res_d[WIDTH-1] : neg_q;
  end

  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a cycle model and directed vectors
module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       reset;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       in_ready, out_valid, zero, carry, negative;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .negative(negative)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Prediction of one request straight from the arithmetic definitions.
  logic [7:0] p_res;
  logic       p_c;
  int         p_lat;
  always_comb begin
    p_res = '0;
    p_c   = 1'b0;
    p_lat = 0;
    case (op)
      3'd0: {p_c, p_res} = {1'b0, a} + {1'b0, b};
      3'd1: begin p_res = a - b; p_c = (a < b); end
      3'd2: if (b == 0) p_res = a;
            else if (b < 8) begin p_res = a >> b; p_c = a[b-1]; p_lat = int'(b); end
      3'd3: if (b == 0) p_res = a;
            else if (b < 8) begin p_res = a << b; p_c = a[8-b]; p_lat = int'(b); end
      3'd4: p_res = a & b;
      3'd5: p_res = a | b;
      3'd6: p_res = a ^ b;
      default: p_res = a;
    endcase
  end

  logic       m_valid = 1'b0;
  int         m_busy = 0;
  logic [7:0] m_res = '0;
  logic       m_c = 1'b0;

  function automatic logic m_ready();
    return (m_busy == 0 && !m_valid) || (m_valid && out_ready);
  endfunction

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_busy  <= 0;
      m_res   <= '0;
      m_c     <= 1'b0;
    end else if (in_valid && m_ready()) begin
      m_res   <= p_res;
      m_c     <= p_c;
      m_busy  <= p_lat;
      m_valid <= (p_lat == 0);
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) m_valid <= 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (!reset && cmp_en) begin
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("result", result, m_res);
        chk("carry", carry, m_c);
        chk("zero", zero, m_res == 8'd0);
        chk("negative", negative, m_res[7]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Issues one request, waits for its result and checks literals; returns at posedge+2 with out_valid high.
  task automatic run(input string name, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] er, input logic ec, input logic ez, input logic en, input int elat);
    int n;
    int busy;
    in_valid = 1'b1; op = o; a = x; b = y;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge CLK); #2; n++; end
    if (!in_ready) chk({name, " accept timeout"}, 0, 1);
    @(posedge CLK); #2;
    in_valid = 1'b0; op = 3'd7; a = ~x; b = 8'hFF;
    n = 1; busy = 0;
    while (!out_valid && n < 100) begin
      if (!in_ready) busy++;
      @(posedge CLK); #2; n++;
    end
    chk({name, " latency"}, n, elat);
    chk({name, " busy cycles"}, busy, elat - 1);
    chk({name, " result"}, result, er);
    chk({name, " carry"}, carry, ec);
    chk({name, " zero"}, zero, ez);
    chk({name, " negative"}, negative, en);
    chk({name, " model result"}, m_res, er);
  endtask

  initial begin
    reset = 1'b1;
    @(posedge CLK); #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst flags", {zero, carry, negative}, 0);
    @(posedge CLK); #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    #1;

    run("add f0+20", 3'd0, 8'hF0, 8'h20, 8'h10, 1, 0, 0, 1);
    idle(2);
    run("sub 5-5", 3'd1, 8'h05, 8'h05, 8'h00, 0, 1, 0, 1);
    chk("b2b in_ready", in_ready, 1);
    run("sub 3-5", 3'd1, 8'h03, 8'h05, 8'hFE, 1, 0, 1, 1);
    run("shl 81<<3", 3'd3, 8'h81, 8'd3, 8'h08, 0, 0, 0, 4);
    run("shr 81>>1", 3'd2, 8'h81, 8'd1, 8'h40, 1, 0, 0, 2);
    run("shl ff<<9", 3'd3, 8'hFF, 8'd9, 8'h00, 0, 1, 0, 1);
    run("shr 5a>>0", 3'd2, 8'h5A, 8'd0, 8'h5A, 0, 0, 0, 1);
    run("shr 80>>8", 3'd2, 8'h80, 8'd8, 8'h00, 0, 1, 0, 1);
    run("shl 03<<7", 3'd3, 8'h03, 8'd7, 8'h80, 1, 0, 1, 8);
    run("shr c0>>7", 3'd2, 8'hC0, 8'd7, 8'h01, 1, 0, 0, 8);
    run("add ff+01", 3'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 1);
    run("and", 3'd4, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 1);
    run("or", 3'd5, 8'h50, 8'h0A, 8'h5A, 0, 0, 0, 1);
    run("pass", 3'd7, 8'h9C, 8'h11, 8'h9C, 0, 0, 1, 1);
    idle(2);

    out_ready = 1'b0;
    run("xor aa^0f", 3'd6, 8'hAA, 8'h0F, 8'hA5, 0, 0, 1, 1);
    in_valid = 1'b1; op = 3'd0; a = 8'h01; b = 8'h02;
    for (int i = 0; i < 3; i++) begin
      chk("stall result", result, 8'hA5);
      chk("stall in_ready", in_ready, 0);
      chk("stall out_valid", out_valid, 1);
      @(posedge CLK); #2;
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", in_ready, 1);
    run("add after stall", 3'd0, 8'h01, 8'h02, 8'h03, 0, 0, 0, 1);
    idle(2);

    in_valid = 1'b1; op = 3'd2; a = 8'h80; b = 8'd7;
    @(posedge CLK); #2;
    in_valid = 1'b0;
    idle(3);
    chk("mid shift in_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst result", result, 0);
    chk("async rst in_ready", in_ready, 1);
    chk("async rst flags", {zero, carry, negative}, 0);
    @(posedge CLK); #2;
    reset = 1'b0;
    #1;
    run("add after rst", 3'd0, 8'h01, 8'h01, 8'h02, 0, 0, 0, 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
